fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch sequencer for the two-accumulator 8-bit core. Owns the program counter, requests 16-bit instruction words from program memory over a request/valid handshake, and presents each word to the instruction decoder. It consumes the decoder's branch-taken / branch-target result to select the next fetch address. It sits between program memory and the decoder and is the only writer of the PC.

## Interface
- ADDR_W, 10, program-memory address width and PC width
- RESET_PC, 0, PC value loaded on reset
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-low reset
- iStall  in  1  hold the currently issued instruction (downstream not ready)
- oMem_req  out  1  fetch request to program memory
- oMem_addr  out  ADDR_W  fetch address; stable while oMem_req=1
- iMem_valid  in  1  memory data valid; honoured only while oMem_req=1
- iMem_data  in  16  instruction word from memory
- oInstruction  out  16  instruction to decoder; 16'h0000 when oInstr_valid=0
- oInstr_valid  out  1  oInstruction is a live fetched word
- oPC  out  ADDR_W  address of oInstruction
- iBranch_taken  in  1  decoder branch decision for oInstruction
- iBranch_dir  in  ADDR_W  decoder branch target; decoder's narrower target is zero-extended at the top level

## Operation
- Internal PC register, ADDR_W bits. Three states: S_RST, S_REQ, S_EXEC.
- S_RST: entered whenever Reset=0. PC<=RESET_PC. All outputs 0: oMem_req=0, oMem_addr=0, oInstruction=0, oInstr_valid=0, oPC=0. Leaves to S_REQ on the first edge with Reset=1.
- S_REQ: oMem_req=1, oMem_addr=PC, oInstr_valid=0, oInstruction=0. On an edge with iMem_valid=1: oInstruction<=iMem_data, oPC<=PC, oInstr_valid<=1, go to S_EXEC. Otherwise stay in S_REQ; a wait state of any length is legal.
- S_EXEC: oMem_req=0, oInstr_valid=1, and oInstruction/oPC are held.
  - iStall=1: stay in S_EXEC; iBranch_taken is ignored.
  - iStall=0 and iBranch_taken=1: PC<=iBranch_dir, go to S_REQ.
  - iStall=0 and iBranch_taken=0: PC<=PC+1 modulo 2^ADDR_W, go to S_REQ.
- iBranch_taken and iBranch_dir are never sampled outside S_EXEC.
- PC increment wraps: max address → 0, with no flag.
- A branch target equal to the current PC is legal and refetches the same word.
- iMem_valid while oMem_req=0 is ignored and has no state effect.
- iMem_data values are never interpreted; any 16-bit word is passed through unchanged.

## Timing
- Reset is synchronous. Reset=0 sampled at an edge forces S_RST after that edge, regardless of state.
  - An outstanding request is abandoned; oMem_req drops the cycle after the reset edge.
  - A late iMem_valid is ignored.
- First oMem_req=1 appears the cycle after the first edge with Reset=1, with oMem_addr=RESET_PC.
- Zero-wait memory (iMem_valid=1 during the request cycle): oInstr_valid=1 the next cycle. Throughput is one instruction per 2 cycles.
- N wait cycles: issue occurs N+1 cycles after the request starts.
- Branch resolution is combinational through the decoder within the S_EXEC cycle. The next oMem_addr appears the cycle after the resolving edge.
- oMem_addr and PC only change on leaving S_EXEC or on reset.

## Test plan
- Reset and start: hold Reset=0 for 3 cycles, then release with RESET_PC=0 and a zero-wait memory.
  - During reset, all outputs are 0.
  - oMem_addr=0 with oMem_req=1 one cycle after release.
  - oInstr_valid=1 two cycles after release.
- Sequential fetch: zero-wait memory, words 16'h1000+addr, no branches. Required:
  - oInstruction sequence 16'h1000, 16'h1001, 16'h1002, each valid for exactly 1 cycle, every 2 cycles.
  - oPC matches each word.
- Branch: when oPC=5, drive iBranch_taken=1 and iBranch_dir=10'h020. The next oMem_addr is 10'h020, and oPC=10'h020 when it issues. The same pattern with iStall=1 for 3 cycles first: the instruction is held for 4 cycles and the branch is taken only after the stall releases.
- Wait states and wrap: delay iMem_valid by 4 cycles with PC=10'h3FF.
  - oMem_addr stays 10'h3FF for 5 cycles.
  - After the instruction issues and the non-branch advance, oMem_addr=0.
- Reset mid-fetch: assert Reset=0 during a request's wait cycles, then pulse iMem_valid=1 while in reset. Required:
  - No issue occurs.
  - oMem_req=0 after the reset edge.
  - Refetch starts from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : fetch sequencer bus (program memory, decoder, stall)
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if #(
  parameter int ADDR_W = 10
);
  logic              iStall;
  logic              oMem_req;
  logic [ADDR_W-1:0] oMem_addr;
  logic              iMem_valid;
  logic [15:0]       iMem_data;
  logic [15:0]       oInstruction;
  logic              oInstr_valid;
  logic [ADDR_W-1:0] oPC;
  logic              iBranch_taken;
  logic [ADDR_W-1:0] iBranch_dir;

  modport master (
    input  iStall, iMem_valid, iMem_data, iBranch_taken, iBranch_dir,
    output oMem_req, oMem_addr, oInstruction, oInstr_valid, oPC
  );

  modport slave (
    output iStall, iMem_valid, iMem_data, iBranch_taken, iBranch_dir,
    input  oMem_req, oMem_addr, oInstruction, oInstr_valid, oPC
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC owner; fetches 16-bit words and hands them to the decoder
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic    Clock,
  input  wire logic    Reset,
  fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [15:0]       r_instr;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_opc;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_next_pc = bus.iBranch_taken ? bus.iBranch_dir : r_pc + ADDR_W'(1);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state       <= S_RST;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr       <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_opc         <= '0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state    <= S_REQ;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_pc;
        end
        S_REQ: begin
          if (bus.iMem_valid) begin
            r_state       <= S_EXEC;
            r_mem_req     <= 1'b0;
            r_instr       <= bus.iMem_data;
            r_opc         <= r_pc;
            r_instr_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          // A stall freezes the issued word; branch inputs are only meaningful once it lifts.
          if (!bus.iStall) begin
            r_state       <= S_REQ;
            r_pc          <= w_next_pc;
            r_mem_req     <= 1'b1;
            r_mem_addr    <= w_next_pc;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_RST;
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
          r_instr       <= 16'h0000;
        end
      endcase
    end
  end

  assign bus.oMem_req     = r_mem_req;
  assign bus.oMem_addr    = r_mem_addr;
  assign bus.oInstruction = r_instr;
  assign bus.oInstr_valid = r_instr_valid;
  assign bus.oPC          = r_opc;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed self-checking bench for fetch_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic Clock;
  logic Reset;
  logic auto_valid;
  logic man_valid;
  int   vectors;
  int   miscompares;

  fetch_unit_if #(.ADDR_W(10)) bus ();

  fetch_unit #(.ADDR_W(10), .RESET_PC(10'h000)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.master)
  );

  // Memory model: word = 16'h1000 + address; zero-wait or manually timed valid.
  assign bus.iMem_data  = 16'h1000 + {6'b0, bus.oMem_addr};
  assign bus.iMem_valid = auto_valid ? bus.oMem_req : man_valid;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic test_reset;
    Reset = 1'b0; auto_valid = 1'b1; man_valid = 1'b0;
    bus.iStall = 1'b0; bus.iBranch_taken = 1'b0; bus.iBranch_dir = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      vectors++;
      if ({bus.oMem_req, bus.oMem_addr, bus.oInstruction, bus.oInstr_valid, bus.oPC} !== 38'd0) begin
        miscompares++;
        $display("FAIL reset_outs[%0d]: got req=%b addr=%h instr=%h v=%b pc=%h, want all 0", i,
                 bus.oMem_req, bus.oMem_addr, bus.oInstruction, bus.oInstr_valid, bus.oPC);
      end
    end
    Reset = 1'b1;
    @(negedge Clock);
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h000 || bus.oInstr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL start_req: got req=%b addr=%h v=%b, want 1 000 0", bus.oMem_req, bus.oMem_addr, bus.oInstr_valid);
    end
    @(negedge Clock);
    vectors++;
    if (bus.oInstr_valid !== 1'b1 || bus.oInstruction !== 16'h1000 || bus.oPC !== 10'h000) begin
      miscompares++;
      $display("FAIL start_issue: got v=%b instr=%h pc=%h, want 1 1000 000", bus.oInstr_valid, bus.oInstruction, bus.oPC);
    end
  endtask

  // Entered in the issue cycle of PC 0.
  task automatic test_sequential;
    logic [15:0] exp_instr;
    logic [9:0]  exp_pc;
    for (int k = 0; k < 4; k++) begin
      exp_instr = 16'h1000 + 16'(k);
      exp_pc    = 10'(k);
      vectors++;
      if (bus.oInstr_valid !== 1'b1 || bus.oInstruction !== exp_instr || bus.oPC !== exp_pc || bus.oMem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_issue[%0d]: got v=%b instr=%h pc=%h req=%b, want 1 %h %h 0", k,
                 bus.oInstr_valid, bus.oInstruction, bus.oPC, bus.oMem_req, exp_instr, exp_pc);
      end
      @(negedge Clock);
      vectors++;
      if (bus.oInstr_valid !== 1'b0 || bus.oInstruction !== 16'h0000 || bus.oMem_req !== 1'b1 || bus.oMem_addr !== exp_pc + 10'd1) begin
        miscompares++;
        $display("FAIL seq_req[%0d]: got v=%b instr=%h req=%b addr=%h, want 0 0000 1 %h", k,
                 bus.oInstr_valid, bus.oInstruction, bus.oMem_req, bus.oMem_addr, exp_pc + 10'd1);
      end
      @(negedge Clock);
    end
  endtask

  task automatic wait_issue(input logic [9:0] pc);
    int n;
    n = 0;
    while (!(bus.oInstr_valid === 1'b1 && bus.oPC === pc) && n < 20) begin
      @(negedge Clock);
      n++;
    end
    vectors++;
    if (n >= 20) begin
      miscompares++;
      $display("FAIL wait_issue: pc %h never issued, last pc=%h v=%b", pc, bus.oPC, bus.oInstr_valid);
    end
  endtask

  task automatic test_branch;
    wait_issue(10'h005);
    bus.iBranch_taken = 1'b1; bus.iBranch_dir = 10'h020;
    @(negedge Clock);
    bus.iBranch_taken = 1'b0; bus.iBranch_dir = 10'h3AA;
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h020) begin
      miscompares++;
      $display("FAIL br_addr: got req=%b addr=%h, want 1 020", bus.oMem_req, bus.oMem_addr);
    end
    @(negedge Clock);
    vectors++;
    if (bus.oInstr_valid !== 1'b1 || bus.oPC !== 10'h020 || bus.oInstruction !== 16'h1020) begin
      miscompares++;
      $display("FAIL br_issue: got v=%b pc=%h instr=%h, want 1 020 1020", bus.oInstr_valid, bus.oPC, bus.oInstruction);
    end
  endtask

  // Entered in the issue cycle of PC 020.
  task automatic test_stall_branch;
    bus.iStall = 1'b1; bus.iBranch_taken = 1'b1; bus.iBranch_dir = 10'h040;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (i == 2) bus.iStall = 1'b0;
      vectors++;
      if (bus.oInstr_valid !== 1'b1 || bus.oPC !== 10'h020 || bus.oInstruction !== 16'h1020 || bus.oMem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h req=%b, want 1 020 1020 0", i,
                 bus.oInstr_valid, bus.oPC, bus.oInstruction, bus.oMem_req);
      end
    end
    @(negedge Clock);
    bus.iBranch_taken = 1'b0;
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h040 || bus.oInstr_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_br_addr: got req=%b addr=%h v=%b, want 1 040 0", bus.oMem_req, bus.oMem_addr, bus.oInstr_valid);
    end
    @(negedge Clock);
  endtask

  // Entered in the issue cycle of PC 040.
  task automatic test_wait_wrap;
    auto_valid = 1'b0; man_valid = 1'b0;
    bus.iBranch_taken = 1'b1; bus.iBranch_dir = 10'h3FF;
    @(negedge Clock);
    bus.iBranch_taken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h3FF || bus.oInstr_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL wait_req[%0d]: got req=%b addr=%h v=%b, want 1 3ff 0", i, bus.oMem_req, bus.oMem_addr, bus.oInstr_valid);
      end
      if (i == 4) man_valid = 1'b1;
      @(negedge Clock);
    end
    man_valid = 1'b0;
    vectors++;
    if (bus.oInstr_valid !== 1'b1 || bus.oPC !== 10'h3FF || bus.oInstruction !== 16'h13FF) begin
      miscompares++;
      $display("FAIL wait_issue: got v=%b pc=%h instr=%h, want 1 3ff 13ff", bus.oInstr_valid, bus.oPC, bus.oInstruction);
    end
    @(negedge Clock);
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL wrap_addr: got req=%b addr=%h, want 1 000", bus.oMem_req, bus.oMem_addr);
    end
  endtask

  // Entered in the request cycle of PC 000 with manual valid.
  task automatic test_reset_mid;
    man_valid = 1'b1;
    @(negedge Clock);
    man_valid = 1'b0;
    @(negedge Clock);
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h001) begin
      miscompares++;
      $display("FAIL mid_pre: got req=%b addr=%h, want 1 001", bus.oMem_req, bus.oMem_addr);
    end
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    man_valid = 1'b1;
    vectors++;
    if (bus.oMem_req !== 1'b0 || bus.oInstr_valid !== 1'b0 || bus.oMem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL mid_drop: got req=%b v=%b addr=%h, want 0 0 000", bus.oMem_req, bus.oInstr_valid, bus.oMem_addr);
    end
    @(negedge Clock);
    man_valid = 1'b0;
    vectors++;
    if ({bus.oMem_req, bus.oMem_addr, bus.oInstruction, bus.oInstr_valid, bus.oPC} !== 38'd0) begin
      miscompares++;
      $display("FAIL mid_noissue: got req=%b addr=%h instr=%h v=%b pc=%h, want all 0",
               bus.oMem_req, bus.oMem_addr, bus.oInstruction, bus.oInstr_valid, bus.oPC);
    end
    Reset = 1'b1; auto_valid = 1'b1;
    @(negedge Clock);
    vectors++;
    if (bus.oMem_req !== 1'b1 || bus.oMem_addr !== 10'h000) begin
      miscompares++;
      $display("FAIL mid_refetch: got req=%b addr=%h, want 1 000", bus.oMem_req, bus.oMem_addr);
    end
    @(negedge Clock);
    vectors++;
    if (bus.oInstr_valid !== 1'b1 || bus.oPC !== 10'h000 || bus.oInstruction !== 16'h1000) begin
      miscompares++;
      $display("FAIL mid_issue: got v=%b pc=%h instr=%h, want 1 000 1000", bus.oInstr_valid, bus.oPC, bus.oInstruction);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_sequential();
    test_branch();
    test_stall_branch();
    test_wait_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
